// File: rtl/note_player_dur_pkg.sv
// Shared types and widths for the duration-timed note player.
// Imported by the player FSM and its frequency ROM.
package note_player_dur_pkg;

    localparam int STEP_W = 20;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int META_W = 3;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_PLAYING,
        ST_PAUSED
    } state_t;

endpackage

// File: rtl/note_player_dur_frequency_rom.sv
// 64 x 20 synchronous pitch-to-phase-increment ROM, one cycle read latency.
// Index 0 is the rest and reads as zero.
module frequency_rom
    import note_player_dur_pkg::*;
(
    input  logic              clk,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] data
);

    // Top-octave increments; lower octaves are right shifts of these.
    function automatic logic [STEP_W-1:0] entry(input logic [NOTE_W-1:0] n);
        logic [NOTE_W-1:0] idx;
        logic [2:0]        oct;
        logic [3:0]        semi;
        logic [STEP_W-1:0] base;
        if (n == NOTE_REST) return '0;
        idx  = n - 6'd1;
        oct  = 3'(idx / 12);
        semi = 4'(idx % 12);
        unique case (semi)
            4'd0:    base = 20'd11121;
            4'd1:    base = 20'd11782;
            4'd2:    base = 20'd12483;
            4'd3:    base = 20'd13225;
            4'd4:    base = 20'd14011;
            4'd5:    base = 20'd14844;
            4'd6:    base = 20'd15727;
            4'd7:    base = 20'd16662;
            4'd8:    base = 20'd17653;
            4'd9:    base = 20'd18703;
            4'd10:   base = 20'd19815;
            default: base = 20'd20993;
        endcase
        return base >> (3'd5 - oct);
    endfunction

    always_ff @(posedge clk) begin
        data <= entry(addr);
    end

endmodule

// File: rtl/note_player_dur.sv
// Note player: looks up a pitch increment and times the note in beats,
// with pause/resume, pre-emption and a one-cycle completion pulse.
module note_player_dur
    import note_player_dur_pkg::*;
#(
    parameter int BEAT_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic [META_W-1:0] metadata,
    output logic [STEP_W-1:0] step_size,
    output logic              note_active,
    output logic              note_done,
    output logic [META_W-1:0] metadata_out
);

    state_t              state;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    dur_q;
    logic [BEAT_W-1:0]   cnt;
    logic [BEAT_W-1:0]   cnt_inc;
    logic [BEAT_W-1:0]   cnt_nxt;
    logic [NOTE_W-1:0]   rom_addr;
    logic [STEP_W-1:0]   rom_data;
    logic                accept;
    logic                finish;

    assign accept = new_note && play
                 && (state == ST_IDLE || state == ST_PLAYING);

    // Address the ROM with the incoming note so the read lands during LOOKUP.
    assign rom_addr = accept ? note : note_q;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign cnt_nxt = beat ? cnt_inc : cnt;
    assign finish  = (32'(cnt_nxt) == 32'(dur_q));

    frequency_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            note_q       <= '0;
            dur_q        <= '0;
            cnt          <= '0;
            step_size    <= '0;
            note_active  <= 1'b0;
            note_done    <= 1'b0;
            metadata_out <= '0;
        end else begin
            note_done <= 1'b0;
            if (accept) begin
                state        <= ST_LOOKUP;
                note_q       <= note;
                dur_q        <= duration;
                metadata_out <= metadata;
                cnt          <= '0;
                note_active  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_LOOKUP: begin
                        state     <= ST_PLAYING;
                        step_size <= rom_data;
                    end
                    ST_PLAYING: begin
                        if (!play) begin
                            state     <= ST_PAUSED;
                            step_size <= '0;
                        end else if (finish) begin
                            state       <= ST_IDLE;
                            cnt         <= cnt_nxt;
                            step_size   <= '0;
                            note_active <= 1'b0;
                            note_done   <= 1'b1;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                    ST_PAUSED: begin
                        if (play) begin
                            state     <= ST_PLAYING;
                            step_size <= rom_data;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_player_dur.sv
// Directed bench for note_player_dur: stimulus queues expected note_done
// events, a monitor pops them as the DUT pulses note_done.
module tb_note_player_dur;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        beat;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic [2:0]  metadata;
    logic [19:0] step_size;
    logic        note_active;
    logic        note_done;
    logic [2:0]  metadata_out;

    typedef struct {
        int         cyc;
        logic [2:0] meta;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    note_player_dur #(.BEAT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .beat         (beat),
        .new_note     (new_note),
        .note         (note),
        .duration     (duration),
        .metadata     (metadata),
        .step_size    (step_size),
        .note_active  (note_active),
        .note_done    (note_done),
        .metadata_out (metadata_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && note_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got note_done=1 at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_meta", int'(metadata_out), int'(e.meta));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_note(input int n, input int d, input int m);
        note     = 6'(n);
        duration = 6'(d);
        metadata = 3'(m);
        new_note = 1'b1;
        next_cycle();
        new_note = 1'b0;
    endtask

    task automatic play_beats(input int n, input int gap,
                              input int m, input bit last);
        for (int i = 0; i < n; i++) begin
            repeat (gap) next_cycle();
            beat = 1'b1;
            if (last && i == n - 1) q.push_back('{cyc + 1, 3'(m)});
            next_cycle();
            beat = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; beat = 1'b0; new_note = 1'b0;
        note = '0; duration = '0; metadata = '0;
        #1;
        chk("rst_step", int'(step_size), 0);
        chk("rst_active", int'(note_active), 0);
        chk("rst_done", int'(note_done), 0);
        chk("rst_meta", int'(metadata_out), 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        play  = 1'b1;
        next_cycle();

        // basic note
        start_note(37, 4, 5);
        chk("basic_lookup_active", int'(note_active), 1);
        chk("basic_lookup_step", int'(step_size), 0);
        next_cycle();
        chk("basic_step", int'(step_size), 2780);
        chk("basic_meta", int'(metadata_out), 5);
        play_beats(4, 2, 5, 1);
        chk("basic_step_after", int'(step_size), 0);
        chk("basic_active_after", int'(note_active), 0);
        next_cycle();

        // pause mid-note
        start_note(20, 6, 2);
        next_cycle();
        chk("pause_step", int'(step_size), 1041);
        play_beats(2, 1, 2, 0);
        play = 1'b0;
        next_cycle();
        chk("paused_step", int'(step_size), 0);
        chk("paused_active", int'(note_active), 1);
        play_beats(10, 1, 2, 0);
        chk("paused_step_late", int'(step_size), 0);
        play = 1'b1;
        next_cycle();
        chk("resume_step", int'(step_size), 1041);
        play_beats(4, 1, 2, 1);
        next_cycle();

        // pre-emption on the third beat
        start_note(10, 8, 1);
        next_cycle();
        chk("pre_first_step", int'(step_size), 584);
        play_beats(2, 1, 1, 0);
        next_cycle();
        beat = 1'b1;
        start_note(12, 2, 3);
        beat = 1'b0;
        next_cycle();
        chk("pre_second_step", int'(step_size), 656);
        chk("pre_second_meta", int'(metadata_out), 3);
        play_beats(2, 1, 3, 1);
        next_cycle();

        // zero duration
        q.push_back('{cyc + 3, 3'd7});
        start_note(37, 0, 7);
        next_cycle();
        chk("dur0_step", int'(step_size), 2780);
        next_cycle();
        chk("dur0_active_after", int'(note_active), 0);
        chk("dur0_step_after", int'(step_size), 0);
        next_cycle();

        // rest note
        start_note(0, 3, 0);
        next_cycle();
        chk("rest_step", int'(step_size), 0);
        chk("rest_active", int'(note_active), 1);
        play_beats(3, 1, 0, 1);
        next_cycle();

        // beat coincident with new_note and LOOKUP is not counted
        beat = 1'b1;
        start_note(20, 1, 1);
        next_cycle();
        beat = 1'b0;
        chk("coin_step", int'(step_size), 1041);
        play_beats(1, 1, 1, 1);
        next_cycle();

        // new_note on the completing beat pre-empts without note_done
        start_note(10, 1, 4);
        next_cycle();
        beat = 1'b1;
        q.push_back('{cyc + 3, 3'd6});
        start_note(5, 0, 6);
        beat = 1'b0;
        next_cycle();
        chk("coin_pre_step", int'(step_size), 437);
        next_cycle();
        next_cycle();

        // asynchronous reset mid-note
        start_note(37, 5, 5);
        next_cycle();
        play_beats(1, 1, 5, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_step", int'(step_size), 0);
        chk("arst_active", int'(note_active), 0);
        chk("arst_meta", int'(metadata_out), 0);
        chk("arst_done", int'(note_done), 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        start_note(12, 1, 2);
        next_cycle();
        chk("post_rst_step", int'(step_size), 656);
        chk("post_rst_meta", int'(metadata_out), 2);
        play_beats(1, 1, 2, 1);
        next_cycle();

        // new_note with play=0 is ignored
        play = 1'b0;
        start_note(37, 0, 7);
        chk("ign_active", int'(note_active), 0);
        next_cycle();
        next_cycle();
        chk("ign_active_late", int'(note_active), 0);
        chk("ign_meta", int'(metadata_out), 2);
        chk("ign_step", int'(step_size), 0);
        play = 1'b1;

        repeat (4) next_cycle();
        chk("pending_done", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_player_dur.md
NOTE_PLAYER_DUR -- requirements
Module: note_player_dur

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- play  in  1  1 = run, 0 = pause
- beat  in  1  one-cycle strobe, 48 Hz
- new_note  in  1  one-cycle strobe: note/duration/metadata valid
- note  in  6  0 = silence, 1..63 = pitch index
- duration  in  6  length in beats, 0 = zero-length
- metadata  in  3  per-note side info, passed through
- step_size  out  20  phase increment for the sine stage, 0 = silent
- note_active  out  1  a note is being timed
- note_done  out  1  one-cycle pulse, note finished
- metadata_out  out  3  metadata of the current note
REQ-003 Parameter: BEAT_W, default 6, width of the beat counter.

Function
REQ-004 States:
- IDLE: no note.
- LOOKUP: one cycle; frequency ROM access in flight.
- PLAYING: counting beats.
- PAUSED: PLAYING frozen.
REQ-005 IDLE, or PLAYING with new_note=1 and play=1 -> LOOKUP on the next edge.
- Latch note, duration and metadata.
- Clear the beat counter.
- A new note pre-empts the running note, and no note_done is issued for the pre-empted note.
REQ-006 new_note while play=0 SHALL be ignored in every state.
REQ-007 LOOKUP -> PLAYING unconditionally.
- step_size = ROM(latched note), valid from the first PLAYING cycle (2-cycle latency from the new_note cycle).
REQ-008 note=0 SHALL give step_size=0, with timing identical to a pitched note.
REQ-009 In PLAYING, each beat=1 cycle with play=1 SHALL increment the counter.
- A beat coincident with the new_note or LOOKUP cycle SHALL NOT count.
REQ-010 When the counter, after incrementing, equals the latched duration:
- On the next edge, note_done=1 for exactly one cycle.
- The state goes to IDLE.
- step_size goes to 0.
REQ-011 duration=0 SHALL complete on the first PLAYING cycle: note_done is asserted 3 cycles after new_note, with no beat needed.
REQ-012 PLAYING with play=0 -> PAUSED.
- The counter holds.
- step_size is forced to 0.
- Beats are ignored.
REQ-013 PAUSED with play=1 -> PLAYING, restoring the latched step_size; the count continues from the held value.
REQ-014 note_active SHALL be 1 in LOOKUP, PLAYING and PAUSED, and 0 in IDLE.
REQ-015 metadata_out SHALL hold the latched metadata until the next accepted new_note.
REQ-016 The counter SHALL saturate at 2^BEAT_W-1 and never wrap.
REQ-017 new_note coincident with a completing beat SHALL give pre-emption only: no note_done.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 Reset SHALL take effect immediately, regardless of clk, including mid-note or in PAUSED.
- state = IDLE
- counter = 0
- step_size = 0
- note_active = 0
- note_done = 0
- metadata_out = 0
- latched fields = 0
REQ-020 The first accepted new_note after reset deassertion SHALL behave as from IDLE.

Structure
REQ-021 A shared package SHALL hold:
- the state encodings
- STEP_W = 20
- NOTE_W = 6
- the NOTE_REST value 0
REQ-022 One sub-module, frequency_rom, SHALL be used: 64 x 20 synchronous ROM, 1-cycle read latency, entry 0 = 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic note: play=1, new_note with note=37, duration=4 -> step_size=ROM[37] 2 cycles later; note_done pulses once, one cycle after the 4th beat; step_size=0 afterwards.
- Pause mid-note: note=20, duration=6; after beat 2, play=0 for 10 beats -> step_size=0, no note_done; resume -> note_done after 4 further beats.
- Pre-emption: note=10, duration=8; new_note note=12, duration=2 at beat 3 -> no note_done for the first note; step_size=ROM[12]; note_done after 2 beats.
- Edge cases: duration=0 -> note_done exactly 3 cycles after new_note. note=0, duration=3 -> step_size stays 0, note_done after 3 beats.
- Reset mid-note: reset asserted between clock edges during PLAYING -> all outputs 0 immediately; later new_note plays normally.
- Coincidence: beat coincident with new_note -> that beat not counted. new_note with play=0 -> ignored, state stays IDLE.
